// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide, one radix-2 step per clock for 32
// clocks. Holds the single-cycle datapath through stall_o while it works.
// Optional build macro: MULDIV_FAST_SPECIAL_EN. When it is defined,
// divide-by-zero, signed overflow and multiply-by-zero finish straight from
// the issue edge instead of running the 32-step loop.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [3:0]      ALU_Operation_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic [XLEN-1:0] result_o,
    output logic            done_o,
    output logic            stall_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    state_t              r_state;
    logic [2:0]          r_op;        // {div, sub-op}; the legal bit is consumed at issue
    logic                r_neg;       // negate the magnitude result at the end
    logic                r_spec;      // operands hit a fixed-result corner case
    logic [XLEN-1:0]     r_spec_res;  // the fixed result for that corner case
    logic [CNT_W-1:0]    r_cnt;
    logic [2*XLEN-1:0]   r_opa;       // mul: multiplicand shifting left; div: divisor
    logic [XLEN-1:0]     r_opb;       // mul: multiplier shifting right; div: dividend -> quotient
    logic [2*XLEN-1:0]   r_acc;       // mul: product; div: partial remainder in low word
    logic [XLEN-1:0]     r_result;
    logic                r_done;

    // ---------------------------------------------------------------
    // Issue-side decode of the incoming request
    // ---------------------------------------------------------------
    logic            w_op_div;
    logic            w_s1;
    logic            w_s2;
    logic            w_neg1;
    logic            w_neg2;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic            w_neg_res;
    logic            w_divz;
    logic            w_ovf;
    logic            w_mulz;
    logic            w_special;
    logic [XLEN-1:0] w_spec_res;

    // Operand signedness, magnitudes, result sign and corner-case detection
    always_comb begin
        w_op_div  = ALU_Operation_i[2];
        // MUL/MULH/MULHSU treat rs1 as signed; MUL/MULH also rs2.
        // DIV/REM (sub-op bit 0 clear) treat both as signed.
        w_s1      = w_op_div ? ~ALU_Operation_i[0] : (ALU_Operation_i[1:0] != 2'b11);
        w_s2      = w_op_div ? ~ALU_Operation_i[0] : ~ALU_Operation_i[1];
        w_neg1    = w_s1 & rs1_data_i[XLEN-1];
        w_neg2    = w_s2 & rs2_data_i[XLEN-1];
        w_abs1    = w_neg1 ? -rs1_data_i : rs1_data_i;
        w_abs2    = w_neg2 ? -rs2_data_i : rs2_data_i;
        // Remainder takes the dividend's sign; everything else the product of signs.
        w_neg_res = (w_op_div & ALU_Operation_i[1]) ? w_neg1 : (w_neg1 ^ w_neg2);

        w_divz    = w_op_div & (rs2_data_i == '0);
        w_ovf     = w_op_div & ~ALU_Operation_i[0] &
                    (rs1_data_i == MIN_NEG) & (rs2_data_i == ALL_ONES);
        w_mulz    = ~w_op_div & ((rs1_data_i == '0) | (rs2_data_i == '0));
        w_special = ALU_Operation_i[3] & (w_divz | w_ovf | w_mulz);

        w_spec_res = '0;
        if (w_divz)
            w_spec_res = ALU_Operation_i[1] ? rs1_data_i : ALL_ONES;
        else if (w_ovf)
            w_spec_res = ALU_Operation_i[1] ? '0 : MIN_NEG;
    end

    // ---------------------------------------------------------------
    // One iteration step and the final result selection
    // ---------------------------------------------------------------
    logic [2*XLEN-1:0] w_mul_acc;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN-1:0]   w_div_sub;
    logic              w_div_ok;
    logic [XLEN-1:0]   w_rem_next;
    logic [XLEN-1:0]   w_quo_next;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo_s;
    logic [XLEN-1:0]   w_rem_s;
    logic [XLEN-1:0]   w_final;

    // Shift-add and restoring-divide datapath, plus sign fix-up of the last step
    always_comb begin
        w_mul_acc   = r_opb[0] ? (r_acc + r_opa) : r_acc;

        // Shift the next dividend bit into the partial remainder and try the
        // subtract. The remainder stays below the divisor, so the shifted
        // value fits in XLEN+1 bits and the low word of the difference is
        // exact whenever the compare succeeds.
        w_div_shift = {r_acc[XLEN-1:0], r_opb[XLEN-1]};
        w_div_ok    = (w_div_shift >= {1'b0, r_opa[XLEN-1:0]});
        w_div_sub   = w_div_shift[XLEN-1:0] - r_opa[XLEN-1:0];
        w_rem_next  = w_div_ok ? w_div_sub : w_div_shift[XLEN-1:0];
        w_quo_next  = {r_opb[XLEN-2:0], w_div_ok};

        w_prod_s    = r_neg ? -w_mul_acc  : w_mul_acc;
        w_quo_s     = r_neg ? -w_quo_next : w_quo_next;
        w_rem_s     = r_neg ? -w_rem_next : w_rem_next;

        if (r_spec)
            w_final = r_spec_res;
        else if (r_op[2])
            w_final = r_op[1] ? w_rem_s : w_quo_s;
        else if (r_op[1:0] == 2'b00)
            w_final = w_prod_s[XLEN-1:0];
        else
            w_final = w_prod_s[2*XLEN-1:XLEN];
    end

    // Control FSM with operand latch, iteration registers and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_neg      <= 1'b0;
            r_spec     <= 1'b0;
            r_spec_res <= '0;
            r_cnt      <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_acc      <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_BUSY: begin
                    if (r_op[2]) begin
                        r_acc <= {{XLEN{1'b0}}, w_rem_next};
                        r_opb <= w_quo_next;
                    end else begin
                        r_acc <= w_mul_acc;
                        r_opa <= r_opa << 1;
                        r_opb <= r_opb >> 1;
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_result <= w_final;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; DONE falls
                    // back to IDLE when none arrives.
                    if (start_i) begin
                        r_op       <= ALU_Operation_i[2:0];
                        r_neg      <= w_neg_res;
                        r_spec     <= w_special;
                        r_spec_res <= w_spec_res;
                        r_cnt      <= '0;
                        // Multiplication commutes, so both op classes load
                        // |rs2| into opa and |rs1| into opb.
                        r_opa      <= {{XLEN{1'b0}}, w_abs2};
                        r_opb      <= w_abs1;
                        r_acc      <= '0;
                        if (!ALU_Operation_i[3]) begin
                            r_result <= '0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
`ifdef MULDIV_FAST_SPECIAL_EN
                        else if (w_special) begin
                            r_result <= w_spec_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
`endif
                        else begin
                            r_state <= S_BUSY;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign result_o = r_result;
    assign done_o   = r_done;
    // The completion cycle does not stall, so writeback happens there even
    // when a back-to-back request is issued in the same cycle.
    assign stall_o  = (r_state == S_BUSY) | (start_i & (r_state != S_BUSY) & ~r_done);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven vectors plus hand sequences for muldiv_unit.
// Expected results and completion cycles go into a scoreboard queue at issue
// and are popped when done_o is seen.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    localparam logic [3:0] OP_MUL = 4'b1000, OP_MULH = 4'b1001, OP_MULHSU = 4'b1010,
                           OP_MULHU = 4'b1011, OP_DIV = 4'b1100, OP_DIVU = 4'b1101,
                           OP_REM = 4'b1110, OP_REMU = 4'b1111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [3:0]  ALU_Operation_i = 4'd0;
    logic [31:0] rs1_data_i = 32'd0;
    logic [31:0] rs2_data_i = 32'd0;
    logic [31:0] result_o;
    logic        done_o;
    logic        stall_o;

    muldiv_unit dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .ALU_Operation_i (ALU_Operation_i),
        .rs1_data_i      (rs1_data_i),
        .rs2_data_i      (rs2_data_i),
        .result_o        (result_o),
        .done_o          (done_o),
        .stall_o         (stall_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[14];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Corner cases that may complete early when the fast path is built in.
    function automatic bit is_special(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[3]) return 1'b0;
        if (op[2]) return (b == 32'h0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
        return (a == 32'h0) || (b == 32'h0);
    endfunction

    function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic        s1, s2;
        logic signed [31:0] sa, sb;
        if (!op[3]) return 32'h0;
        if (!op[2]) begin
            s1 = (op[1:0] != 2'b11);
            s2 = !op[1];
            ea = {{32{s1 & a[31]}}, a};
            eb = {{32{s2 & b[31]}}, b};
            p  = ea * eb;
            return (op[1:0] == 2'b00) ? p[31:0] : p[63:32];
        end
        if (b == 32'h0) return op[1] ? a : 32'hFFFFFFFF;
        if (!op[0]) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'h0 : 32'h80000000;
            sa = a;
            sb = b;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int lat_of(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[3]) return 0;
        return (FAST && is_special(op, a, b)) ? 0 : 32;
    endfunction

    // Scoreboard: every done_o pulse must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done_o) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done_o=1 want no pulse (cycle %0d, result %h)", cyc, result_o);
                end else begin
                    e = sb_q.pop_front();
                    check32("result", result_o, e.res);
                    check32("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // Called just after a negedge with the DUT idle: request stalls in its own
    // issue cycle, then inputs are scrambled to prove they were latched.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
        start_i = 1'b1;
        ALU_Operation_i = op;
        rs1_data_i = a;
        rs2_data_i = b;
        #1;
        check32("issue_stall", 32'(stall_o), 32'd1);
        if (push) sb_q.push_back('{ref_res(op, a, b), cyc + 1 + lat_of(op, a, b)});
        @(posedge clk);
        #1;
        start_i = 1'b0;
        ALU_Operation_i = ~op;
        rs1_data_i = $urandom;
        rs2_data_i = $urandom;
    endtask

    // Wait until the scoreboard drains, then one more cycle so DUT is IDLE.
    task automatic wait_idle();
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            #2;
            if (sb_q.size() == 0) begin
                @(negedge clk);
                #2;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL timeout: got %0d outstanding want 0", sb_q.size());
        sb_q.delete();
    endtask

    initial begin
        int stall_err;
        int dones;
        bit seen;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
        vecs[1]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[2]  = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
        vecs[4]  = '{OP_DIV,    32'hFFFFFFEC, 32'h00000003, 32'hFFFFFFFA};
        vecs[5]  = '{OP_REM,    32'hFFFFFFEC, 32'h00000003, 32'hFFFFFFFE};
        vecs[6]  = '{OP_DIVU,   32'd100,      32'd7,        32'd14};
        vecs[7]  = '{OP_REMU,   32'd100,      32'd7,        32'd2};
        vecs[8]  = '{OP_DIVU,   32'h12345678, 32'h00000000, 32'hFFFFFFFF};
        vecs[9]  = '{OP_REM,    32'd5,        32'h00000000, 32'd5};
        vecs[10] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[11] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        vecs[12] = '{OP_MUL,    32'h00000000, 32'h00001234, 32'h00000000};
        vecs[13] = '{OP_DIV,    32'hFFFFFF9C, 32'h00000000, 32'hFFFFFFFF};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("reset_result", result_o, 32'h0);
        check32("reset_done", 32'(done_o), 32'd0);
        check32("reset_stall", 32'(stall_o), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #2;

        // MUL 7 x -3 with stall tracked every cycle up to completion
        sb_q.push_back('{32'hFFFFFFEB, cyc + 1 + 32});
        start_i = 1'b1;
        ALU_Operation_i = OP_MUL;
        rs1_data_i = 32'd7;
        rs2_data_i = 32'hFFFFFFFD;
        #1;
        check32("mul_issue_stall", 32'(stall_o), 32'd1);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        stall_err = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (done_o) begin
                seen = 1'b1;
                check32("mul_done_stall", 32'(stall_o), 32'd0);
            end else if (!stall_o) begin
                stall_err++;
            end
        end
        check32("mul_busy_stall_errs", 32'(stall_err), 32'd0);
        check32("mul_done_seen", 32'(seen), 32'd1);
        wait_idle();

        // Table vectors; expected values are the hand-derived table entries
        for (int i = 0; i < 14; i++) begin
            sb_q.push_back('{vecs[i].exp, cyc + 1 + lat_of(vecs[i].op, vecs[i].a, vecs[i].b)});
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            wait_idle();
        end

        // start while BUSY is ignored
        issue(OP_MUL, 32'd3, 32'd4, 1'b1);
        repeat (9) @(negedge clk);
        #2;
        start_i = 1'b1;
        ALU_Operation_i = OP_DIVU;
        rs1_data_i = 32'd100;
        rs2_data_i = 32'd7;
        #1;
        check32("busy_start_stall", 32'(stall_o), 32'd1);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_idle();

        // Back-to-back: new request issued in the DONE cycle
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            #2;
            if (done_o) seen = 1'b1;
        end
        check32("b2b_first_done", 32'(seen), 32'd1);
        start_i = 1'b1;
        ALU_Operation_i = OP_REMU;
        rs1_data_i = 32'd100;
        rs2_data_i = 32'd7;
        #1;
        check32("b2b_done_cycle_stall", 32'(stall_o), 32'd0);
        sb_q.push_back('{32'd2, cyc + 1 + 32});
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_idle();

        // Illegal op: zero result, done right after the issue edge
        issue(4'b0000, 32'h1234, 32'h5678, 1'b1);
        wait_idle();

        // Random operations against the reference model
        for (int i = 0; i < 20; i++) begin
            rop = 4'(8 + $urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: ra = 32'h0;
                default: ;
            endcase
            issue(rop, ra, rb, 1'b1);
            wait_idle();
        end

        // Reset in the middle of a DIV: abandoned, no completion
        issue(OP_DIV, 32'hFFFFFFEC, 32'd3, 1'b1);
        sb_q.delete();
        issue(OP_MUL, 32'd5, 32'd9, 1'b1);
        sb_q.delete();
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check32("midreset_result", result_o, 32'h0);
        check32("midreset_done", 32'(done_o), 32'd0);
        check32("midreset_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        check32("midreset_no_done", 32'(dones), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU operation code the decoder produces, plus the two register operands.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over 32 iteration cycles.
- Raises a stall to the single-cycle datapath while busy, so PC and register writeback hold until the result is ready.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start_i  input  1  request; accepted only in IDLE or DONE.
- ALU_Operation_i  input  4  op code from ALU control: 1000 MUL, 1001 MULH, 1010 MULHSU, 1011 MULHU, 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
- rs1_data_i  input  32  dividend / multiplicand.
- rs2_data_i  input  32  divisor / multiplier.
- result_o  output  32  registered result.
- done_o  output  1  one-cycle completion pulse.
- stall_o  output  1  combinational hold request to the PC/writeback.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state IDLE, result_o=0, done_o=0, counter=0, internal operand/accumulator registers=0.
- Reset mid-operation: abandons the computation; no done_o pulse; result_o=0 after the edge.
- State IDLE:
  - start_i=1 at edge E0 latches the op code and operands.
  - Signed ops store absolute values plus result-sign flags.
  - Transition to BUSY with counter=0.
  - An op code with MSB=0 is illegal: go straight to DONE with result_o=0.
- State BUSY:
  - One radix-2 step per edge (shift-add multiply, restoring divide); counter increments.
  - After the 32nd step (E32) load result_o (sign-corrected, selecting the high or low product word, or quotient/remainder) and go to DONE.
- State DONE:
  - done_o=1 for exactly one cycle (between E32 and E33).
  - Then go to IDLE, or restart at once if start_i=1 in that cycle (back-to-back).
  - result_o holds until the next accepted start completes.
- Latency: done_o first high 32 cycles after the start cycle.
- stall_o = (state==BUSY) | (start_i & state!=BUSY & !done_o). A new request stalls in its own issue cycle; the completing cycle does not stall, so writeback occurs there.
- start_i while BUSY is ignored; latched operands must not change.
- MULH: signed×signed. MULHSU: rs1 signed, rs2 unsigned. MULHU: unsigned; upper 32 bits of the 64-bit product.
- Division by zero:
  - DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU remainder = rs1.
  - No exception.
- Signed overflow (0x80000000 / 0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- Remainder sign follows the dividend; quotient truncates toward zero.

Optional Feature:
- Macro MULDIV_FAST_SPECIAL_EN.
- When defined:
  - Divide-by-zero and signed-overflow cases skip BUSY.
  - They go IDLE→DONE at E0 with the spec result; done_o is high in the cycle after start.
  - A multiply with either operand zero also completes this way with result 0.
- When undefined: every legal op takes the full 32-step BUSY path; results are identical, only latency differs.

Test Plan:
- MUL 7 × 0xFFFFFFFD (−3) → result_o=0xFFFFFFEB, done_o pulses exactly 32 cycles after start, stall_o high from start cycle through the cycle before done.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULH same operands → 0x00000000; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFEC (−20) / 3 → 0xFFFFFFFA; REM same operands → 0xFFFFFFFE; DIVU 100/7 → 14, REMU → 2.
- DIVU 0x12345678 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0. Latency 32 without MULDIV_FAST_SPECIAL_EN, 1 with it.
- Assert start_i with new operands at cycle 10 of a BUSY MUL 3×4 → ignored, result 12. Back-to-back start in the DONE cycle → second result correct, no idle gap.
- Assert reset at cycle 15 of a DIV → next cycle state IDLE, result_o=0, done_o never pulses. Illegal op 0000 → result 0, done_o in the next cycle.
